spi_master_xfer_ctrl: RTL

//  Synthesizable SPI master transfer sequencer. Accepts one DATA_WIDTH word per request and

---
 rtl/spi_globals_pkg.sv | 41 ++++
 rtl/spi_master_xfer_ctrl_if.sv | 43 ++++
 rtl/spi_sclk_gen.sv | 49 ++++
 rtl/spi_master_xfer_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_globals_pkg.sv
// Shared types and defaults for the SPI master transfer sequencer.
package spi_globals_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } shift_direction_e;

    // Encoded as {cpol, cpha}.
    typedef enum logic [1:0] {
        CPOL0_CPHA0 = 2'd0,
        CPOL0_CPHA1 = 2'd1,
        CPOL1_CPHA0 = 2'd2,
        CPOL1_CPHA1 = 2'd3
    } spi_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } xfer_state_e;

    localparam int DEF_C2T_DELAY = 1;
    localparam int DEF_T2C_DELAY = 1;
    localparam int DEF_WDELAY    = 1;

    function automatic spi_mode_e make_mode(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

    function automatic logic mode_cpol(input spi_mode_e m);
        return (m == CPOL1_CPHA0) || (m == CPOL1_CPHA1);
    endfunction

    function automatic logic mode_cpha(input spi_mode_e m);
        return (m == CPOL0_CPHA1) || (m == CPOL1_CPHA1);
    endfunction

endpackage

// File: rtl/spi_master_xfer_ctrl_if.sv
// Host request/response, configuration and SPI pin bundle for the transfer sequencer.
interface spi_master_xfer_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 1,
    parameter int BAUD_W       = 8
);
    localparam int SEL_W = $clog2(NO_OF_SLAVES) + 1;

    logic                    req_valid;
    logic                    req_ready;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [SEL_W-1:0]        req_cs_sel;
    logic                    cfg_cpol;
    logic                    cfg_cpha;
    logic                    cfg_lsb_first;
    logic [BAUD_W-1:0]       cfg_baud_div;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    busy;
    logic                    sclk;
    logic [NO_OF_SLAVES-1:0] cs;
    logic                    mosi0;
    logic                    miso0;

    // The sequencer itself.
    modport master (
        input  req_valid, req_data, req_cs_sel,
        input  cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_baud_div,
        input  miso0,
        output req_ready, rsp_valid, rsp_data, busy,
        output sclk, cs, mosi0
    );

    // Host front end plus the addressed SPI device.
    modport slave (
        output req_valid, req_data, req_cs_sel,
        output cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_baud_div,
        output miso0,
        input  req_ready, rsp_valid, rsp_data, busy,
        input  sclk, cs, mosi0
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// Baud divider and SPI clock generator. Produces a half-period tick and, when the
// caller opens the edge window, toggles sclk and flags the leading/trailing edge.
module spi_sclk_gen #(
    parameter int BAUD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              idle_lvl,
    input  logic              cpol,
    input  logic              edge_win,
    input  logic [BAUD_W-1:0] div,
    output logic              sclk,
    output logic              tick,
    output logic              lead_stb,
    output logic              trail_stb
);

    logic [BAUD_W-1:0] cnt;
    logic              edge_stb;

    assign tick      = run && (cnt == div);
    assign edge_stb  = tick && edge_win;
    assign lead_stb  = edge_stb && (sclk == cpol);
    assign trail_stb = edge_stb && (sclk != cpol);

    // Half-period counter: parked at zero while idle, wraps on every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // sclk follows the live idle level when stopped and toggles on windowed ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk <= 1'b0;
        end else if (!run) begin
            sclk <= idle_lvl;
        end else if (edge_stb) begin
            sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_xfer_ctrl.sv
// SPI master transfer sequencer: one word per accepted request, programmable
// mode, bit order and baud, received word returned with a one-cycle pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | req_ready high, sclk tracks cfg_cpol, waiting for a request
// ST_SETUP | cs asserted, sclk at idle level for C2T_DELAY half periods
// ST_XFER  | 2*DATA_WIDTH half periods, one sclk edge entering each one
// ST_HOLD  | sclk idle, mosi held for T2C_DELAY half periods; response at exit
// ST_GAP   | cs released, WDELAY half periods before accepting again
//
// The first sclk edge lands exactly C2T_DELAY half periods after cs assert; the
// last edge opens the final XFER half period, so the HOLD delay follows one idle
// half period of XFER.
module spi_master_xfer_ctrl
    import spi_globals_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 1,
    parameter int BAUD_W       = 8,
    parameter int C2T_DELAY    = DEF_C2T_DELAY,
    parameter int T2C_DELAY    = DEF_T2C_DELAY,
    parameter int WDELAY       = DEF_WDELAY
) (
    input  logic pclk,
    input  logic areset,
    spi_master_xfer_ctrl_if.master bus
);

    localparam int SEL_W  = $clog2(NO_OF_SLAVES) + 1;
    localparam int HCNT_W = $clog2(2*DATA_WIDTH + C2T_DELAY + T2C_DELAY + WDELAY + 1);
    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [HCNT_W-1:0] SETUP_LOAD = HCNT_W'(C2T_DELAY - 1);
    localparam logic [HCNT_W-1:0] XFER_LOAD  = HCNT_W'(2*DATA_WIDTH - 1);
    localparam logic [HCNT_W-1:0] HOLD_LOAD  = HCNT_W'(T2C_DELAY - 1);
    localparam logic [HCNT_W-1:0] GAP_LOAD   = HCNT_W'((WDELAY > 0) ? WDELAY - 1 : 0);
    localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(DATA_WIDTH - 1);

    xfer_state_e             state, state_nxt;
    logic [HCNT_W-1:0]       hcnt, hcnt_nxt;
    spi_mode_e               mode_lat;
    shift_direction_e        dir_lat;
    logic [BAUD_W-1:0]       div_lat;
    logic [SEL_W-1:0]        sel_lat;
    logic [DATA_WIDTH-1:0]   tx_sr;
    logic [DATA_WIDTH-1:0]   rx_sr;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [BCNT_W-1:0]       bit_cnt;
    logic                    mosi_q;
    logic                    rsp_valid_q;
    logic                    accept;
    logic                    tick;
    logic                    lead_stb;
    logic                    trail_stb;
    logic                    edge_win;
    logic                    hold_done;
    logic                    shift_out;
    logic                    sample_in;
    logic                    cs_active;
    logic                    sclk_int;
    logic [NO_OF_SLAVES-1:0] cs_n;

    assign accept    = bus.req_valid && (state == ST_IDLE);
    assign hold_done = (state == ST_HOLD) && tick && (hcnt == '0);
    assign edge_win  = ((state == ST_SETUP) && (hcnt == '0)) ||
                       ((state == ST_XFER)  && (hcnt != '0));
    assign cs_active = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);

    // cpha=0 presents the next bit on the trailing edge (first bit already out at
    // accept, last trailing edge leaves mosi alone); cpha=1 presents on leading edges.
    assign shift_out = mode_cpha(mode_lat) ? lead_stb : (trail_stb && (bit_cnt != LAST_BIT));
    assign sample_in = mode_cpha(mode_lat) ? trail_stb : lead_stb;

    spi_sclk_gen #(
        .BAUD_W (BAUD_W)
    ) u_sclk_gen (
        .clk       (pclk),
        .rst_n     (areset),
        .run       (state != ST_IDLE),
        .idle_lvl  (bus.cfg_cpol),
        .cpol      (mode_cpol(mode_lat)),
        .edge_win  (edge_win),
        .div       (div_lat),
        .sclk      (sclk_int),
        .tick      (tick),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    // State register and half-period down-counter.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state <= ST_IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    // Next state: each non-idle state lasts until its half-period count expires.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                    hcnt_nxt  = SETUP_LOAD;
                end
            end
            ST_SETUP, ST_XFER, ST_HOLD, ST_GAP: begin
                if (tick) begin
                    if (hcnt != '0) begin
                        hcnt_nxt = hcnt - 1'b1;
                    end else if (state == ST_SETUP) begin
                        state_nxt = ST_XFER;
                        hcnt_nxt  = XFER_LOAD;
                    end else if (state == ST_XFER) begin
                        state_nxt = ST_HOLD;
                        hcnt_nxt  = HOLD_LOAD;
                    end else if ((state == ST_HOLD) && (WDELAY > 0)) begin
                        state_nxt = ST_GAP;
                        hcnt_nxt  = GAP_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                        hcnt_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hcnt_nxt  = '0;
            end
        endcase
    end

    // Transfer datapath: latch request/config on accept, then shift on sclk strobes.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            mode_lat <= CPOL0_CPHA0;
            dir_lat  <= MSB_FIRST;
            div_lat  <= '0;
            sel_lat  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            mosi_q   <= 1'b0;
        end else if (accept) begin
            mode_lat <= make_mode(bus.cfg_cpol, bus.cfg_cpha);
            dir_lat  <= shift_direction_e'(bus.cfg_lsb_first);
            div_lat  <= bus.cfg_baud_div;
            sel_lat  <= bus.req_cs_sel;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            if (!bus.cfg_cpha) begin
                mosi_q <= bus.cfg_lsb_first ? bus.req_data[0] : bus.req_data[DATA_WIDTH-1];
                tx_sr  <= bus.cfg_lsb_first ? (bus.req_data >> 1) : (bus.req_data << 1);
            end else begin
                tx_sr  <= bus.req_data;
            end
        end else begin
            if (trail_stb) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_out) begin
                mosi_q <= (dir_lat == LSB_FIRST) ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
                tx_sr  <= (dir_lat == LSB_FIRST) ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (sample_in) begin
                rx_sr <= (dir_lat == LSB_FIRST) ? {bus.miso0, rx_sr[DATA_WIDTH-1:1]}
                                                : {rx_sr[DATA_WIDTH-2:0], bus.miso0};
            end
        end
    end

    // Response: one-cycle pulse as HOLD expires, data held until the next pulse.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= hold_done;
            if (hold_done) begin
                rsp_data_q <= rx_sr;
            end
        end
    end

    // Chip-select decode; an out-of-range index leaves every select high.
    always_comb begin
        cs_n = '1;
        if (cs_active) begin
            for (int i = 0; i < NO_OF_SLAVES; i++) begin
                if (sel_lat == SEL_W'(i)) begin
                    cs_n[i] = 1'b0;
                end
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.sclk      = sclk_int;
    assign bus.cs        = cs_n;
    assign bus.mosi0     = mosi_q;

endmodule
